// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control unit for the multi-cycle MIPS-subset datapath.
// Sequences add/sub/ori/lw/sw/beq/lui/jal/jr through FETCH, DECODE, EXEC,
// MEM and WB, and drives the datapath mux selects and write enables.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   en               advance enable (0 freezes the FSM and all write enables)
//   special, offest  opcode / funct fields of the IR
//   zero             ALU result is zero (beq decision in EXEC)
//   ALUop, EXTop, NPCop, RAsel, RWsel, ABsel   datapath selects
//   IRWE, PCWE, GRFWE, DMWE                    architectural write enables
//   illegal          pulse in DECODE for an undecodable instruction
//   instr_done       copy of PCWE (last cycle of an instruction)
//   state            current FSM state (debug)
module multi_cycle_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] special,
  input  logic [5:0] offest,
  input  logic       zero,
  output logic [2:0] ALUop,
  output logic [2:0] EXTop,
  output logic [2:0] NPCop,
  output logic [2:0] RAsel,
  output logic [2:0] RWsel,
  output logic [2:0] ABsel,
  output logic       IRWE,
  output logic       PCWE,
  output logic       GRFWE,
  output logic       DMWE,
  output logic       illegal,
  output logic       instr_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_BAD
  } instr_e;

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  instr_e     ins;

  logic irwe, pcwe, grfwe, dmwe, ill, bad_state;

  // Instruction classification from the IR fields.
  always_comb begin
    ins = I_BAD;
    case (special)
      6'b000000: begin
        case (offest)
          6'b100000: ins = I_ADD;
          6'b100010: ins = I_SUB;
          6'b001000: ins = I_JR;
          default:   ins = I_BAD;
        endcase
      end
      6'b001101: ins = I_ORI;
      6'b100011: ins = I_LW;
      6'b101011: ins = I_SW;
      6'b000100: ins = I_BEQ;
      6'b001111: ins = I_LUI;
      6'b000011: ins = I_JAL;
      default:   ins = I_BAD;
    endcase
  end

  // Datapath selects: purely a function of the instruction, in every state.
  always_comb begin
    ALUop = '0;
    EXTop = '0;
    RAsel = '0;
    RWsel = '0;
    ABsel = '0;
    case (ins)
      I_SUB: ALUop = 3'b001;
      I_ORI: begin
        ALUop = 3'b011;
        EXTop = 3'b001;
        RAsel = 3'b001;
        ABsel = 3'b001;
      end
      I_LW: begin
        RAsel = 3'b001;
        RWsel = 3'b010;
        ABsel = 3'b001;
      end
      I_SW:  ABsel = 3'b001;
      I_BEQ: ALUop = 3'b001;
      I_LUI: begin
        EXTop = 3'b010;
        RAsel = 3'b001;
        RWsel = 3'b001;
      end
      I_JAL: begin
        RAsel = 3'b010;
        RWsel = 3'b011;
      end
      default: ;
    endcase
  end

  // Next state and raw (ungated) write enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    irwe      = 1'b0;
    pcwe      = 1'b0;
    grfwe     = 1'b0;
    dmwe      = 1'b0;
    ill       = 1'b0;
    bad_state = 1'b0;
    NPCop     = 3'b000;
    case (state_q)
      S_FETCH: begin
        irwe    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ins)
          I_JAL: begin
            grfwe   = 1'b1;
            pcwe    = 1'b1;
            NPCop   = 3'b010;
            state_d = S_FETCH;
          end
          I_JR: begin
            pcwe    = 1'b1;
            NPCop   = 3'b011;
            state_d = S_FETCH;
          end
          I_LUI: state_d = S_WB;
          I_BAD: begin
            ill     = 1'b1;
            pcwe    = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (ins)
          I_BEQ: begin
            pcwe    = 1'b1;
            NPCop   = zero ? 3'b001 : 3'b000;
            state_d = S_FETCH;
          end
          I_LW, I_SW: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == MEM_LAST) begin
          if (ins == I_SW) begin
            dmwe    = 1'b1;
            pcwe    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        grfwe   = 1'b1;
        pcwe    = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        bad_state = 1'b1;
        state_d   = S_FETCH;
      end
    endcase
    // A stall holds everything, except that a corrupt state still recovers.
    if (!en && !bad_state) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enables are gated by rst_n so nothing writes while reset is held.
  logic gate;
  assign gate       = en & rst_n;
  assign IRWE       = irwe  & gate;
  assign PCWE       = pcwe  & gate;
  assign GRFWE      = grfwe & gate;
  assign DMWE       = dmwe  & gate;
  assign illegal    = ill   & gate;
  assign instr_done = PCWE;
  assign state      = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl (MEM_LAT = 3).
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, zero;
  logic [5:0] special, offest;
  logic [2:0] ALUop, EXTop, NPCop, RAsel, RWsel, ABsel, state;
  logic       IRWE, PCWE, GRFWE, DMWE, illegal, instr_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.MEM_LAT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .special(special), .offest(offest),
    .zero(zero), .ALUop(ALUop), .EXTop(EXTop), .NPCop(NPCop), .RAsel(RAsel),
    .RWsel(RWsel), .ABsel(ABsel), .IRWE(IRWE), .PCWE(PCWE), .GRFWE(GRFWE),
    .DMWE(DMWE), .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  // Selects packed as {ALUop, EXTop, RAsel, RWsel, ABsel}.
  localparam logic [14:0] SEL_ADD = 15'b000_000_000_000_000;
  localparam logic [14:0] SEL_SUB = 15'b001_000_000_000_000;
  localparam logic [14:0] SEL_ORI = 15'b011_001_001_000_001;
  localparam logic [14:0] SEL_LW  = 15'b000_000_001_010_001;
  localparam logic [14:0] SEL_SW  = 15'b000_000_000_000_001;
  localparam logic [14:0] SEL_BEQ = 15'b001_000_000_000_000;
  localparam logic [14:0] SEL_LUI = 15'b000_010_001_001_000;
  localparam logic [14:0] SEL_JAL = 15'b000_000_010_011_000;
  localparam logic [14:0] SEL_NIL = 15'b000_000_000_000_000;

  // Enables packed as {IRWE, PCWE, GRFWE, DMWE, illegal}.
  typedef struct {
    logic [5:0]  sp;
    logic [5:0]  fn;
    logic        z;
    logic        en;
    logic [2:0]  st;
    logic [4:0]  we;
    logic [2:0]  npc;
    logic [14:0] sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] sp, logic [5:0] fn, logic z, logic e,
                              logic [2:0] st, logic [4:0] we, logic [2:0] npc,
                              logic [14:0] sel);
    vec_t v;
    v.sp = sp; v.fn = fn; v.z = z; v.en = e;
    v.st = st; v.we = we; v.npc = npc; v.sel = sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] we_now();
    return {IRWE, PCWE, GRFWE, DMWE, illegal};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // add
    vecs.push_back(mk(6'o00, 6'h20, 0, 1, 0, 5'b10000, 0, SEL_ADD));
    vecs.push_back(mk(6'o00, 6'h20, 0, 1, 1, 5'b00000, 0, SEL_ADD));
    vecs.push_back(mk(6'o00, 6'h20, 0, 1, 2, 5'b00000, 0, SEL_ADD));
    vecs.push_back(mk(6'o00, 6'h20, 0, 1, 4, 5'b01100, 0, SEL_ADD));
    // lw, MEM_LAT = 3
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_LW));
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 1, 5'b00000, 0, SEL_LW));
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 2, 5'b00000, 0, SEL_LW));
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 3, 5'b00000, 0, SEL_LW));
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 3, 5'b00000, 0, SEL_LW));
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 3, 5'b00000, 0, SEL_LW));
    vecs.push_back(mk(6'h23, 6'h00, 0, 1, 4, 5'b01100, 0, SEL_LW));
    // sw
    vecs.push_back(mk(6'h2b, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_SW));
    vecs.push_back(mk(6'h2b, 6'h00, 0, 1, 1, 5'b00000, 0, SEL_SW));
    vecs.push_back(mk(6'h2b, 6'h00, 0, 1, 2, 5'b00000, 0, SEL_SW));
    vecs.push_back(mk(6'h2b, 6'h00, 0, 1, 3, 5'b00000, 0, SEL_SW));
    vecs.push_back(mk(6'h2b, 6'h00, 0, 1, 3, 5'b00000, 0, SEL_SW));
    vecs.push_back(mk(6'h2b, 6'h00, 0, 1, 3, 5'b01010, 0, SEL_SW));
    // beq taken, then not taken
    vecs.push_back(mk(6'h04, 6'h00, 1, 1, 0, 5'b10000, 0, SEL_BEQ));
    vecs.push_back(mk(6'h04, 6'h00, 1, 1, 1, 5'b00000, 0, SEL_BEQ));
    vecs.push_back(mk(6'h04, 6'h00, 1, 1, 2, 5'b01000, 1, SEL_BEQ));
    vecs.push_back(mk(6'h04, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_BEQ));
    vecs.push_back(mk(6'h04, 6'h00, 0, 1, 1, 5'b00000, 0, SEL_BEQ));
    vecs.push_back(mk(6'h04, 6'h00, 0, 1, 2, 5'b01000, 0, SEL_BEQ));
    // jal
    vecs.push_back(mk(6'h03, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_JAL));
    vecs.push_back(mk(6'h03, 6'h00, 0, 1, 1, 5'b01100, 2, SEL_JAL));
    // illegal opcode
    vecs.push_back(mk(6'h3f, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_NIL));
    vecs.push_back(mk(6'h3f, 6'h00, 0, 1, 1, 5'b01001, 0, SEL_NIL));
    // lui
    vecs.push_back(mk(6'h0f, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_LUI));
    vecs.push_back(mk(6'h0f, 6'h00, 0, 1, 1, 5'b00000, 0, SEL_LUI));
    vecs.push_back(mk(6'h0f, 6'h00, 0, 1, 4, 5'b01100, 0, SEL_LUI));
    // ori with a one-cycle stall in EXEC
    vecs.push_back(mk(6'h0d, 6'h00, 0, 1, 0, 5'b10000, 0, SEL_ORI));
    vecs.push_back(mk(6'h0d, 6'h00, 0, 1, 1, 5'b00000, 0, SEL_ORI));
    vecs.push_back(mk(6'h0d, 6'h00, 0, 0, 2, 5'b00000, 0, SEL_ORI));
    vecs.push_back(mk(6'h0d, 6'h00, 0, 1, 2, 5'b00000, 0, SEL_ORI));
    vecs.push_back(mk(6'h0d, 6'h00, 0, 1, 4, 5'b01100, 0, SEL_ORI));
    // sub
    vecs.push_back(mk(6'o00, 6'h22, 0, 1, 0, 5'b10000, 0, SEL_SUB));
    vecs.push_back(mk(6'o00, 6'h22, 0, 1, 1, 5'b00000, 0, SEL_SUB));
    vecs.push_back(mk(6'o00, 6'h22, 0, 1, 2, 5'b00000, 0, SEL_SUB));
    vecs.push_back(mk(6'o00, 6'h22, 0, 1, 4, 5'b01100, 0, SEL_SUB));
    // jr
    vecs.push_back(mk(6'o00, 6'h08, 0, 1, 0, 5'b10000, 0, SEL_NIL));
    vecs.push_back(mk(6'o00, 6'h08, 0, 1, 1, 5'b01000, 3, SEL_NIL));

    // Reset state with en high: FETCH, but no enable may fire.
    rst_n = 1'b0; en = 1'b1; zero = 1'b0; special = 6'o00; offest = 6'h20;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_we", 32'({we_now(), instr_done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      special = vecs[i].sp;
      offest  = vecs[i].fn;
      zero    = vecs[i].z;
      en      = vecs[i].en;
      #1;
      check($sformatf("vec%0d", i),
            {state, we_now(), instr_done, NPCop, ALUop, EXTop, RAsel, RWsel, ABsel},
            {vecs[i].st, vecs[i].we, vecs[i].we[3], vecs[i].npc, vecs[i].sel});
      @(negedge clk);
    end

    // lw stalled for 5 cycles on the first MEM cycle, then reset mid-WB.
    special = 6'h23; offest = 6'h00; en = 1'b1; zero = 1'b0;
    #1 check("stall_fetch", 32'(state), 32'd0);
    @(negedge clk);
    #1 check("stall_decode", 32'(state), 32'd1);
    @(negedge clk);
    #1 check("stall_exec", 32'(state), 32'd2);
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("stall_hold%0d", k), 32'({state, we_now()}), 32'({3'd3, 5'b00000}));
      @(negedge clk);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("stall_mem%0d", k), 32'({state, we_now()}), 32'({3'd3, 5'b00000}));
      @(negedge clk);
    end
    #1 check("stall_wb", 32'({state, we_now(), RWsel}), 32'({3'd4, 5'b01100, 3'b010}));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({state, we_now(), instr_done}), 32'({3'd0, 5'b00000, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("after_reset", 32'({state, we_now()}), 32'({3'd0, 5'b10000}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
